// File: rtl/pong_match_controller_pkg.sv
// Shared types and constants for the pong match controller: phase encoding,
// default timing/width parameters, display/paddle widths and the width-shrink helper.
package pong_match_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    localparam int SCORE_W           = 4;
    localparam int PW_W              = 6;
    localparam int SERVE_DELAY_DEF   = 25000000;
    localparam int WIDTH_MAX_DEF     = 48;
    localparam int WIDTH_MIN_DEF     = 16;
    localparam int WIDTH_STEP_DEF    = 4;
    localparam int HITS_PER_STEP_DEF = 4;
    localparam int WIN_SCORE_DEF     = 9;

    // Narrow the paddle by one step without ever going below the floor.
    function automatic logic [PW_W-1:0] shrink_width(input logic [PW_W-1:0] w,
                                                     input int step,
                                                     input int floor_w);
        if (int'(w) >= floor_w + step) begin
            return w - PW_W'(step);
        end else begin
            return PW_W'(floor_w);
        end
    endfunction

endpackage

// File: rtl/pong_match_controller_if.sv
// Bundle between the match controller (slave) and the ball/display datapath (master).
interface pong_match_controller_if;
    import pong_match_controller_pkg::*;

    logic               start_btn;
    logic               miss_0;
    logic               miss_1;
    logic               paddle_hit;
    logic [SCORE_W-1:0] num_0;
    logic [SCORE_W-1:0] num_1;
    logic [PW_W-1:0]    paddlewidth;
    logic               ball_run;
    logic               ball_center;
    logic               serve_dir;
    logic               game_over;
    logic               winner;

    modport master (
        output start_btn, miss_0, miss_1, paddle_hit,
        input  num_0, num_1, paddlewidth, ball_run, ball_center,
               serve_dir, game_over, winner
    );

    modport slave (
        input  start_btn, miss_0, miss_1, paddle_hit,
        output num_0, num_1, paddlewidth, ball_run, ball_center,
               serve_dir, game_over, winner
    );

endinterface

// File: rtl/pong_match_controller_serve_delay_timer.sv
// One-shot serve hold timer: start_i arms it, done_o is high on the last
// of SERVE_DELAY cycles after arming.
module serve_delay_timer
    import pong_match_controller_pkg::*;
#(
    parameter int SERVE_DELAY = SERVE_DELAY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic done_o
);

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_DELAY - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;

    // Count-up while armed; done is precomputed so it can be registered.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            cnt_d = {CNT_W{1'b0}};
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == LAST) begin
                cnt_d = {CNT_W{1'b0}};
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        done_d = run_d && (cnt_d == LAST);
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= {CNT_W{1'b0}};
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer: owns scores and paddle width, gates ball motion through
// serve / play / point / game-over phases.
module pong_match_controller
    import pong_match_controller_pkg::*;
#(
    parameter int SERVE_DELAY   = SERVE_DELAY_DEF,
    parameter int WIDTH_MAX     = WIDTH_MAX_DEF,
    parameter int WIDTH_MIN     = WIDTH_MIN_DEF,
    parameter int WIDTH_STEP    = WIDTH_STEP_DEF,
    parameter int HITS_PER_STEP = HITS_PER_STEP_DEF,
    parameter int WIN_SCORE     = WIN_SCORE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    pong_match_controller_if.slave bus
);

    localparam int HC_W = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;
    localparam logic [HC_W-1:0]    HIT_LAST = HC_W'(HITS_PER_STEP - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [PW_W-1:0]    PW_MAX   = PW_W'(WIDTH_MAX);

    state_e             state_q, state_d;
    logic               start_q;
    logic [SCORE_W-1:0] num_0_q, num_0_d, num_1_q, num_1_d;
    logic [PW_W-1:0]    pw_q, pw_d;
    logic [HC_W-1:0]    hit_q, hit_d;
    logic               dir_q, dir_d, win_q, win_d;
    logic               center_q, center_d, run_q, over_q;
    logic               start_edge_s, serve_start_s, delay_done_s;

    assign start_edge_s  = bus.start_btn && !start_q;
    assign serve_start_s = (state_d == ST_SERVE) && (state_q != ST_SERVE);

    serve_delay_timer #(.SERVE_DELAY(SERVE_DELAY)) u_serve_delay_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (serve_start_s),
        .done_o  (delay_done_s)
    );

    // Next-state and next-output logic for the match phases.
    always_comb begin
        state_d  = state_q;
        num_0_d  = num_0_q;
        num_1_d  = num_1_q;
        pw_d     = pw_q;
        hit_d    = hit_q;
        dir_d    = dir_q;
        win_d    = win_q;
        center_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_d  = ST_SERVE;
                    num_0_d  = {SCORE_W{1'b0}};
                    num_1_d  = {SCORE_W{1'b0}};
                    center_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (delay_done_s) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_PLAY: begin
                // A simultaneous double miss is a replay; a miss always beats a hit.
                if (bus.miss_0 && bus.miss_1) begin
                    state_d  = ST_SERVE;
                    center_d = 1'b1;
                end else if (bus.miss_0) begin
                    num_1_d = num_1_q + SCORE_W'(1);
                    dir_d   = 1'b0;
                    state_d = ST_POINT;
                end else if (bus.miss_1) begin
                    num_0_d = num_0_q + SCORE_W'(1);
                    dir_d   = 1'b1;
                    state_d = ST_POINT;
                end else if (bus.paddle_hit) begin
                    if (hit_q == HIT_LAST) begin
                        hit_d = {HC_W{1'b0}};
                        pw_d  = shrink_width(pw_q, WIDTH_STEP, WIDTH_MIN);
                    end else begin
                        hit_d = hit_q + HC_W'(1);
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_POINT: begin
                pw_d  = PW_MAX;
                hit_d = {HC_W{1'b0}};
                if ((num_0_q == WIN) || (num_1_q == WIN)) begin
                    state_d = ST_GAME_OVER;
                    win_d   = (num_1_q == WIN);
                end else begin
                    state_d  = ST_SERVE;
                    center_d = 1'b1;
                end
            end
            ST_GAME_OVER: begin
                if (start_edge_s) begin
                    state_d  = ST_SERVE;
                    num_0_d  = {SCORE_W{1'b0}};
                    num_1_d  = {SCORE_W{1'b0}};
                    pw_d     = PW_MAX;
                    hit_d    = {HC_W{1'b0}};
                    dir_d    = 1'b0;
                    center_d = 1'b1;
                end else begin
                    state_d = ST_GAME_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            num_0_q  <= {SCORE_W{1'b0}};
            num_1_q  <= {SCORE_W{1'b0}};
            pw_q     <= PW_MAX;
            hit_q    <= {HC_W{1'b0}};
            dir_q    <= 1'b0;
            win_q    <= 1'b0;
            center_q <= 1'b0;
            run_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.start_btn;
            num_0_q  <= num_0_d;
            num_1_q  <= num_1_d;
            pw_q     <= pw_d;
            hit_q    <= hit_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            center_q <= center_d;
            run_q    <= (state_d == ST_PLAY);
            over_q   <= (state_d == ST_GAME_OVER);
        end
    end

    assign bus.num_0       = num_0_q;
    assign bus.num_1       = num_1_q;
    assign bus.paddlewidth = pw_q;
    assign bus.ball_run    = run_q;
    assign bus.ball_center = center_q;
    assign bus.serve_dir   = dir_q;
    assign bus.game_over   = over_q;
    assign bus.winner      = win_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed match scenarios plus random pulses,
// checked every cycle against a phase-level model of the match rules.
module tb_pong_match_controller;
    import pong_match_controller_pkg::*;

    localparam int SD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pong_match_controller_if bus();

    pong_match_controller #(
        .SERVE_DELAY(SD), .WIDTH_MAX(48), .WIDTH_MIN(16),
        .WIDTH_STEP(4), .HITS_PER_STEP(4), .WIN_SCORE(9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: phase 0 idle, 1 serve, 2 play, 3 point, 4 over.
    int m_phase, m_left, m_hits, m_n0, m_n1;
    bit m_dir, m_win, m_center, m_prev;

    function automatic int exp_width();
        int w;
        w = 48 - 4 * (m_hits / 4);
        return (w < 16) ? 16 : w;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(bit st, bit m0, bit m1, bit h, bit rst);
        bit edge_s;
        if (rst) begin
            m_phase = 0; m_left = 0; m_hits = 0; m_n0 = 0; m_n1 = 0;
            m_dir = 0; m_win = 0; m_center = 0; m_prev = 0;
            return;
        end
        edge_s   = st && !m_prev;
        m_prev   = st;
        m_center = 0;
        case (m_phase)
            0: if (edge_s) begin
                m_phase = 1; m_left = SD; m_n0 = 0; m_n1 = 0; m_center = 1;
            end
            1: begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
            2: begin
                if (m0 && m1) begin
                    m_phase = 1; m_left = SD; m_center = 1;
                end else if (m0) begin
                    m_n1++; m_dir = 0; m_phase = 3;
                end else if (m1) begin
                    m_n0++; m_dir = 1; m_phase = 3;
                end else if (h) begin
                    m_hits++;
                end
            end
            3: begin
                m_hits = 0;
                if (m_n0 == 9 || m_n1 == 9) begin
                    m_phase = 4; m_win = (m_n1 == 9);
                end else begin
                    m_phase = 1; m_left = SD; m_center = 1;
                end
            end
            default: if (edge_s) begin
                m_phase = 1; m_left = SD; m_n0 = 0; m_n1 = 0; m_hits = 0;
                m_dir = 0; m_center = 1;
            end
        endcase
    endtask

    task automatic cyc(bit st, bit m0, bit m1, bit h, bit rst);
        bus.start_btn  = st;
        bus.miss_0     = m0;
        bus.miss_1     = m1;
        bus.paddle_hit = h;
        reset          = rst;
        @(posedge clk);
        model(st, m0, m1, h, rst);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic wait_play();
        int k = 0;
        while (m_phase != 2 && k < 50) begin
            cyc(0, 0, 0, 0, 0);
            k++;
        end
        checks++;
        if (m_phase != 2) begin
            errors++;
            $display("FAIL wait_play: timed out after %0d cycles", k);
        end
    endtask

    // After entering SERVE: ball held for SD cycles in total, then released.
    task automatic serve_check(string nm);
        chk({nm, "_center"}, bus.ball_center, 1);
        chk({nm, "_hold0"}, bus.ball_run, 0);
        for (int i = 1; i < SD; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk({nm, "_hold"}, bus.ball_run, 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk({nm, "_launch"}, bus.ball_run, 1);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("num_0",       bus.num_0,       m_n0);
            chk("num_1",       bus.num_1,       m_n1);
            chk("paddlewidth", bus.paddlewidth, exp_width());
            chk("ball_run",    bus.ball_run,    (m_phase == 2));
            chk("ball_center", bus.ball_center, m_center);
            chk("serve_dir",   bus.serve_dir,   m_dir);
            chk("game_over",   bus.game_over,   (m_phase == 4));
            chk("winner",      bus.winner,      m_win);
        end
    end

    initial begin
        bus.start_btn = 0; bus.miss_0 = 0; bus.miss_1 = 0; bus.paddle_hit = 0;
        reset = 1;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_num_0", bus.num_0, 0);
        chk("rst_width", bus.paddlewidth, 48);
        chk("rst_run", bus.ball_run, 0);
        idle(2);

        cyc(1, 0, 0, 0, 0);
        chk("start_scores", {bus.num_0, bus.num_1}, 0);
        serve_check("serve1");

        for (int i = 1; i <= 40; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (i == 3)  chk("width_hit3", bus.paddlewidth, 48);
            if (i == 4)  chk("width_hit4", bus.paddlewidth, 44);
            if (i == 8)  chk("width_hit8", bus.paddlewidth, 40);
            if (i == 32) chk("width_hit32", bus.paddlewidth, 16);
            if (i == 40) chk("width_hit40", bus.paddlewidth, 16);
        end

        cyc(0, 1, 0, 0, 0);
        chk("miss0_num1", bus.num_1, 1);
        chk("miss0_dir", bus.serve_dir, 0);
        chk("miss0_run", bus.ball_run, 0);
        cyc(0, 0, 0, 0, 0);
        chk("point_width", bus.paddlewidth, 48);
        serve_check("serve2");

        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        chk("miss0b_num1", bus.num_1, 2);
        cyc(0, 0, 0, 0, 0);
        wait_play();

        cyc(0, 1, 1, 1, 0);
        chk("dbl_num0", bus.num_0, 0);
        chk("dbl_num1", bus.num_1, 2);
        chk("dbl_width", bus.paddlewidth, 48);
        serve_check("replay");

        for (int p = 0; p < 9; p++) begin
            wait_play();
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        chk("go_num0", bus.num_0, 9);
        chk("go_flag", bus.game_over, 1);
        chk("go_winner", bus.winner, 0);
        chk("go_run", bus.ball_run, 0);
        idle(3);
        cyc(0, 1, 0, 1, 0);
        idle(2);
        chk("go_hold_num0", bus.num_0, 9);
        chk("go_hold_num1", bus.num_1, 2);

        cyc(1, 0, 0, 0, 0);
        chk("restart_num0", bus.num_0, 0);
        chk("restart_flag", bus.game_over, 0);
        chk("restart_center", bus.ball_center, 1);
        cyc(0, 0, 0, 0, 0);
        wait_play();
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        wait_play();
        cyc(0, 0, 0, 1, 1);
        chk("midrst_num0", bus.num_0, 0);
        chk("midrst_width", bus.paddlewidth, 48);
        chk("midrst_run", bus.ball_run, 0);
        chk("midrst_center", bus.ball_center, 0);
        chk("midrst_dir", bus.serve_dir, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 16) == 0, ($urandom % 30) == 0, ($urandom % 30) == 0,
                ($urandom % 3) == 0, ($urandom % 700) == 0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
